// File: rtl/elm_argmax_seq_pkg.sv
// ---------------------------------------------------------------------------
// elm_argmax_seq_pkg
//   Shared definitions for the ELM output-layer argmax path: state encoding
//   of the sequential argmax FSM and default score / class-index widths that
//   the MAC stage and result register reuse.
// ---------------------------------------------------------------------------
package elm_argmax_seq_pkg;

   // Default widths shared across the output layer
   localparam int ELM_DATA_W      = 32;
   localparam int ELM_IDX_W       = 4;
   localparam int ELM_NUM_CLASSES = 10;

   // FSM state encoding
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] ACC  = 2'd1;
   localparam logic [1:0] HOLD = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE = IDLE,
      ST_ACC  = ACC,
      ST_HOLD = HOLD
   } state_t;

endpackage

// File: rtl/elm_max_cmp.sv
// ---------------------------------------------------------------------------
// elm_max_cmp
//   Combinational strict unsigned compare of a candidate score against the
//   current maximum.
//   i_cand    candidate score
//   i_cur     current running maximum
//   o_gt      1 when i_cand > i_cur (unsigned, strict)
//   o_sel_max larger of the two; i_cur on a tie
// ---------------------------------------------------------------------------
module elm_max_cmp
   import elm_argmax_seq_pkg::*;
#(
   parameter int DATA_W = ELM_DATA_W
) (
   input  logic [DATA_W-1:0] i_cand,
   input  logic [DATA_W-1:0] i_cur,
   output logic              o_gt,
   output logic [DATA_W-1:0] o_sel_max
);

   // Ties keep the current value so the earliest class index wins
   assign o_gt      = (i_cand > i_cur);
   assign o_sel_max = o_gt ? i_cand : i_cur;

endmodule

// File: rtl/elm_argmax_seq.sv
// ---------------------------------------------------------------------------
// elm_argmax_seq
//   Sequential argmax over NUM_CLASSES unsigned scores, one per handshake.
//   Tracks the running maximum and its class index, then holds the result
//   on a valid/ready port until it is consumed.
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_start           begin a classification (honoured only in IDLE)
//   i_in_valid        score beat valid
//   i_in_data         score beat; class index = beat order, 0 first
//   o_in_ready        high while accumulating
//   o_out_valid       result valid (HOLD)
//   i_out_ready       result consumer ready
//   o_out_max         winning score
//   o_out_idx         winning class index
//   o_busy            high while accumulating or holding a result
// ---------------------------------------------------------------------------
module elm_argmax_seq
   import elm_argmax_seq_pkg::*;
#(
   parameter int DATA_W      = ELM_DATA_W,
   parameter int NUM_CLASSES = ELM_NUM_CLASSES,
   parameter int IDX_W       = ELM_IDX_W
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic              i_in_valid,
   input  logic [DATA_W-1:0] i_in_data,
   output logic              o_in_ready,
   output logic              o_out_valid,
   input  logic              i_out_ready,
   output logic [DATA_W-1:0] o_out_max,
   output logic [IDX_W-1:0]  o_out_idx,
   output logic              o_busy
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

   state_t              r_state;
   state_t              w_next;
   logic [IDX_W-1:0]    r_cnt;
   logic [DATA_W-1:0]   r_max;
   logic [IDX_W-1:0]    r_idx;

   logic                w_beat;
   logic                w_last;
   logic                w_first;
   logic                w_gt;
   logic                w_take;
   logic [DATA_W-1:0]   w_sel_max;

   assign w_beat  = (r_state == ST_ACC) && i_in_valid;
   assign w_last  = w_beat && (r_cnt == LAST_IDX);
   assign w_first = (r_cnt == '0);

   elm_max_cmp #(
      .DATA_W    (DATA_W)
   ) u_cmp (
      .i_cand    (i_in_data),
      .i_cur     (r_max),
      .o_gt      (w_gt),
      .o_sel_max (w_sel_max)
   );

   // Beat 0 always loads, so a stale max from the previous run never leaks in
   assign w_take = w_first || w_gt;

   // ---------------- FSM ----------------
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_state <= ST_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: if (i_start)     w_next = ST_ACC;
         ST_ACC:  if (w_last)      w_next = ST_HOLD;
         ST_HOLD: if (i_out_ready) w_next = ST_IDLE;
         default:                  w_next = ST_IDLE;
      endcase
   end

   // ---------------- Datapath ----------------
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt <= '0;
         r_max <= '0;
         r_idx <= '0;
      end else begin
         if (r_state == ST_IDLE && i_start)
            r_cnt <= '0;
         if (w_beat) begin
            r_cnt <= w_last ? '0 : r_cnt + IDX_W'(1);
            if (w_take) begin
               r_max <= w_first ? i_in_data : w_sel_max;
               r_idx <= r_cnt;
            end
         end
      end
   end

   // Outputs are decodes of registered state / registers only
   assign o_in_ready  = (r_state == ST_ACC);
   assign o_out_valid = (r_state == ST_HOLD);
   assign o_busy      = (r_state != ST_IDLE);
   assign o_out_max   = r_max;
   assign o_out_idx   = r_idx;

endmodule
